dmem_responder: RTL

- Memory-side responder for the processor's data-memory port: it accepts one load or store at a time from the datapath and answers after a programmable number of wait states.
- Holds a word-addressed array with per-byte write enables.
- Flags misaligned or out-of-range accesses instead of performing them.
- Lets the multi-cycle datapath be exercised against a memory that is not single-cycle.

---
 rtl/dmem_pkg.sv | 7 +
 rtl/dmem_array.sv | 26 ++
 rtl/flopenr.sv | 15 +
 rtl/dmem_responder.sv | 106 ++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
    localparam int unsigned WCNT_W = 4;
    localparam int unsigned NBYTES = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: byte-enabled synchronous write, combinational read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = 6
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [NBYTES-1:0] i_be,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_idx];
endmodule

// File: rtl/flopenr.sv
// Resettable register with load enable.
module flopenr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: serialised loads/stores answered after LATENCY wait
// states, with misalignment / range faults reported instead of performed.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned REQ_W = 1 + 32 + 32 + NBYTES;
    localparam logic [WCNT_W-1:0] WINIT = (LATENCY == 0) ? '0 : WCNT_W'(LATENCY - 1);

    state_t              r_state;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [REQ_W-1:0]    w_req_d;
    logic [REQ_W-1:0]    w_req_q;
    logic                w_accept;
    logic                w_commit;
    logic                w_we;
    logic                w_fault;
    logic                w_mem_we;
    logic [31:0]         w_addr;
    logic [31:0]         w_wdata;
    logic [NBYTES-1:0]   w_be;
    logic [31:0]         w_mem_rdata;

    assign w_accept = (r_state == IDLE) && req;
    assign w_req_d  = {we, addr, wdata, be};

    flopenr #(.WIDTH(REQ_W)) u_req_latch (
        .clk   (clk),
        .reset (reset),
        .en    (w_accept),
        .d     (w_req_d),
        .q     (w_req_q)
    );

    // With LATENCY=0 the commit edge is the acceptance edge, so the live inputs are used
    assign {w_we, w_addr, w_wdata, w_be} = (r_state == IDLE) ? w_req_d : w_req_q;

    assign w_fault  = (w_addr[1:0] != 2'b00) || ({2'b00, w_addr[31:2]} >= 32'(DEPTH));
    assign w_commit = (LATENCY == 0) ? w_accept : ((r_state == WAIT) && (r_wcnt == '0));
    assign w_mem_we = w_commit && w_we && !w_fault;

    dmem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_be    (w_be),
        .i_idx   (w_addr[IDX_W+1:2]),
        .i_wdata (w_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    ready <= 1'b0;
                    err   <= 1'b0;
                    rdata <= '0;
                    if (req) begin
                        if (LATENCY == 0) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                            r_wcnt  <= WINIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_wcnt == '0) r_state <= RESP;
                    else              r_wcnt  <= r_wcnt - 1'b1;
                end
                RESP: begin
                    r_state <= IDLE;
                    ready   <= 1'b0;
                    err     <= 1'b0;
                    rdata   <= '0;
                end
                default: r_state <= IDLE;
            endcase
            if (w_commit) begin
                ready <= 1'b1;
                err   <= w_fault;
                rdata <= (w_fault || w_we) ? '0 : w_mem_rdata;
            end
        end
    end
endmodule
